// File: rtl/sprite_row_fetch.sv
// Sprite row fetcher: during horizontal blank, finds which sprite slots cover
// the next scanline, reads their 32-bit pixel rows from sprite RAM into a
// shadow buffer, and publishes the buffer at the start of active video.
module sprite_row_fetch #(
  parameter int unsigned NSPR = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_start,
  input  logic                 line_commit,
  input  logic [9:0]           CounterY,
  input  logic [NSPR-1:0]      spr_en,
  input  logic [9*NSPR-1:0]    spr_posy,
  input  logic [NSPR-1:0]      spr_flipy,
  input  logic [6*NSPR-1:0]    spr_tile,
  output logic [10:0]          mem_addr,
  output logic                 mem_rd,
  input  logic                 mem_ack,
  input  logic [15:0]          mem_data,
  output logic [32*NSPR-1:0]   colors,
  output logic [NSPR-1:0]      row_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned SW = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NSPR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ_LO,
    S_REQ_HI,
    S_NEXT,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [SW-1:0]       slot_q;
  logic                stale_q;

  logic [8:0]          cy_q;
  logic [NSPR-1:0]     en_q;
  logic [9*NSPR-1:0]   posy_q;
  logic [NSPR-1:0]     flip_q;
  logic [6*NSPR-1:0]   tile_q;

  logic [32*NSPR-1:0]  shadow_q;
  logic [NSPR-1:0]     shadow_vld_q;

  logic [10:0]         mem_addr_q;
  logic                mem_rd_q;
  logic [32*NSPR-1:0]  colors_q;
  logic [NSPR-1:0]     row_valid_q;
  logic                busy_q;
  logic                overrun_q;

  logic                start_c;
  logic                en_sel_c;
  logic                flip_sel_c;
  logic [8:0]          posy_sel_c;
  logic [5:0]          tile_sel_c;
  logic [8:0]          rely_c;
  logic                hit_c;
  logic [3:0]          row_c;
  logic [10:0]         addr_lo_c;
  logic                unused_c;

  // Line LSB does not affect half-resolution sprite rows
  assign unused_c = CounterY[0];

  // A new fetch may begin when idle or when the previous result was never committed
  assign start_c = line_start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Capture line number and sprite attributes for the whole fetch
  always_ff @(posedge clk) begin
    if (!rst) begin
      cy_q   <= '0;
      en_q   <= '0;
      posy_q <= '0;
      flip_q <= '0;
      tile_q <= '0;
    end else if (start_c) begin
      cy_q   <= CounterY[9:1];
      en_q   <= spr_en;
      posy_q <= spr_posy;
      flip_q <= spr_flipy;
      tile_q <= spr_tile;
    end
  end

  // Select the attributes of the slot currently being examined
  always_comb begin
    en_sel_c   = 1'b0;
    flip_sel_c = 1'b0;
    posy_sel_c = '0;
    tile_sel_c = '0;
    for (int unsigned i = 0; i < NSPR; i++) begin
      if (slot_q == SW'(i)) begin
        en_sel_c   = en_q[i];
        flip_sel_c = flip_q[i];
        posy_sel_c = posy_q[9*i +: 9];
        tile_sel_c = tile_q[6*i +: 6];
      end
    end
  end

  // Vertical offset into the sprite wraps modulo 512 so sprites can straddle the top edge
  assign rely_c    = cy_q - posy_sel_c;
  assign hit_c     = en_sel_c && (rely_c[8:4] == 5'd0);
  assign row_c     = flip_sel_c ? ~rely_c[3:0] : rely_c[3:0];
  assign addr_lo_c = {tile_sel_c, row_c, 1'b0};

  // Fetch sequencer, shadow buffer, publication and error tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      stale_q      <= 1'b0;
      shadow_q     <= '0;
      shadow_vld_q <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      colors_q     <= '0;
      row_valid_q  <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            slot_q  <= '0;
            busy_q  <= 1'b1;
            stale_q <= 1'b0;
            state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (hit_c) begin
            mem_addr_q <= addr_lo_c;
            mem_rd_q   <= 1'b1;
            state_q    <= S_REQ_LO;
          end else begin
            for (int unsigned i = 0; i < NSPR; i++) begin
              if (slot_q == SW'(i)) begin
                shadow_q[32*i +: 32] <= '0;
                shadow_vld_q[i]      <= 1'b0;
              end
            end
            state_q <= S_NEXT;
          end
        end

        S_REQ_LO: begin
          if (mem_ack) begin
            for (int unsigned i = 0; i < NSPR; i++) begin
              if (slot_q == SW'(i)) begin
                shadow_q[32*i +: 16] <= mem_data;
              end
            end
            mem_addr_q <= {mem_addr_q[10:1], 1'b1};
            state_q    <= S_REQ_HI;
          end
        end

        S_REQ_HI: begin
          if (mem_ack) begin
            for (int unsigned i = 0; i < NSPR; i++) begin
              if (slot_q == SW'(i)) begin
                shadow_q[32*i+16 +: 16] <= mem_data;
                shadow_vld_q[i]         <= 1'b1;
              end
            end
            mem_rd_q <= 1'b0;
            state_q  <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (slot_q == LAST_SLOT) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            slot_q  <= slot_q + SW'(1);
            state_q <= S_CHECK;
          end
        end

        S_DONE: begin
          // Commit is handled before a simultaneous start; a stale result is never shown
          if (line_commit && !stale_q) begin
            colors_q    <= shadow_q;
            row_valid_q <= shadow_vld_q;
          end
          if (start_c) begin
            slot_q  <= '0;
            busy_q  <= 1'b1;
            stale_q <= 1'b0;
            state_q <= S_CHECK;
          end else if (line_commit && !stale_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase

      // Line events arriving mid-fetch: blank the display and flag the overrun
      if (busy_q) begin
        if (line_commit) begin
          colors_q    <= '0;
          row_valid_q <= '0;
          overrun_q   <= 1'b1;
          stale_q     <= 1'b1;
        end
        if (line_start) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign colors    = colors_q;
  assign row_valid = row_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
